// File: rtl/aes_cbc_dec_chain_pkg.sv
// Shared types and helpers for the AES-256 CBC decrypt chaining stage.
// Holds the block width, the chaining state encoding and the FIFO entry layout.
package aes_cbc_dec_chain_pkg;

    localparam int AES_BLOCK_WIDTH = 128;
    localparam int CT_ENTRY_WIDTH  = AES_BLOCK_WIDTH + 1;

    typedef enum logic {
        FIRST = 1'b0,
        CHAIN = 1'b1
    } cbc_state_t;

    typedef struct packed {
        logic                       last;
        logic [AES_BLOCK_WIDTH-1:0] data;
    } ct_entry_t;

    // Block XORed into the raw decrypt result: IV at a packet start, else the previous ciphertext.
    function automatic logic [AES_BLOCK_WIDTH-1:0] chain_mask(
        input cbc_state_t                 st,
        input logic [AES_BLOCK_WIDTH-1:0] iv,
        input logic [AES_BLOCK_WIDTH-1:0] prev_ct
    );
        logic [AES_BLOCK_WIDTH-1:0] mask;
        case (st)
            FIRST:   mask = iv;
            CHAIN:   mask = prev_ct;
            default: mask = iv;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/aes_cbc_dec_chain_ct_fifo.sv
// Ciphertext delay FIFO: holds {tlast, block} from the pipeline input until the
// matching decrypted block emerges. Reports full/empty/count and error pulses.
module aes_ct_fifo
    import aes_cbc_dec_chain_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        push_i,
    input  ct_entry_t   push_data_i,
    input  logic        pop_i,
    output ct_entry_t   pop_data_o,
    output logic        full_o,
    output logic        empty_o,
    output logic [AW:0] count_o,
    output logic        overflow_o,
    output logic        underflow_o
);

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] wr_ptr_d;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_ptr_d;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          push_ok;
    logic          pop_ok;
    ct_entry_t     mem_q [DEPTH];

    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign empty_o    = (count_q == {(AW+1){1'b0}});
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Accept/drop decisions, pointer advance and occupancy update.
    always_comb begin
        pop_ok      = pop_i && !empty_o;
        push_ok     = push_i && (!full_o || pop_ok);
        overflow_o  = push_i && full_o && !pop_i;
        underflow_o = pop_i && empty_o;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; cleared on reset so a flushed FIFO never leaks old ciphertext.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/aes_cbc_dec_chain.sv
// CBC chaining stage behind the AES-256 inverse-cipher pipeline: XORs each raw
// decrypted block with the IV or previous ciphertext and flags FIFO/tlast errors.
module aes_cbc_dec_chain
    import aes_cbc_dec_chain_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [AES_BLOCK_WIDTH-1:0] iv_i,
    input  logic                       iv_valid_i,
    input  logic [AES_BLOCK_WIDTH-1:0] ct_tdata,
    input  logic                       ct_tvalid,
    input  logic                       ct_tlast,
    input  logic [AES_BLOCK_WIDTH-1:0] dec_tdata,
    input  logic                       dec_tvalid,
    input  logic                       dec_tlast,
    output logic [AES_BLOCK_WIDTH-1:0] pt_tdata,
    output logic                       pt_tvalid,
    output logic                       pt_tlast,
    output logic                       err_overflow_o,
    output logic                       err_underflow_o,
    output logic                       err_sync_o
);

    localparam int AW = $clog2(DEPTH);

    cbc_state_t                 state_q;
    cbc_state_t                 state_d;
    logic [AES_BLOCK_WIDTH-1:0] iv_q;
    logic [AES_BLOCK_WIDTH-1:0] iv_d;
    logic [AES_BLOCK_WIDTH-1:0] prev_ct_q;
    logic [AES_BLOCK_WIDTH-1:0] prev_ct_d;
    logic [AES_BLOCK_WIDTH-1:0] pt_tdata_q;
    logic [AES_BLOCK_WIDTH-1:0] pt_tdata_d;
    logic                       pt_tvalid_q;
    logic                       pt_tvalid_d;
    logic                       pt_tlast_q;
    logic                       pt_tlast_d;
    logic                       err_overflow_q;
    logic                       err_overflow_d;
    logic                       err_underflow_q;
    logic                       err_underflow_d;
    logic                       err_sync_q;
    logic                       err_sync_d;

    ct_entry_t                  fifo_push_data;
    ct_entry_t                  fifo_pop_data;
    ct_entry_t                  pop_entry;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [AW:0]                fifo_count;
    logic                       fifo_overflow;
    logic                       fifo_underflow;
    logic                       unused_fifo_status;

    assign fifo_push_data     = '{last: ct_tlast, data: ct_tdata};
    assign unused_fifo_status = ^{fifo_full, fifo_count};

    aes_ct_fifo #(
        .DEPTH (DEPTH)
    ) u_ct_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .push_i      (ct_tvalid),
        .push_data_i (fifo_push_data),
        .pop_i       (dec_tvalid),
        .pop_data_o  (fifo_pop_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .overflow_o  (fifo_overflow),
        .underflow_o (fifo_underflow)
    );

    // An empty pop still produces a beat; it chains against an all-zero ciphertext.
    always_comb begin
        if (fifo_empty) begin
            pop_entry = '0;
        end else begin
            pop_entry = fifo_pop_data;
        end
    end

    // Chaining state machine, plaintext formation and sticky error capture.
    always_comb begin
        state_d         = state_q;
        iv_d            = iv_q;
        prev_ct_d       = prev_ct_q;
        pt_tdata_d      = pt_tdata_q;
        pt_tvalid_d     = 1'b0;
        pt_tlast_d      = 1'b0;
        err_overflow_d  = err_overflow_q;
        err_underflow_d = err_underflow_q;
        err_sync_d      = err_sync_q;

        if (iv_valid_i) begin
            iv_d = iv_i;
        end else begin
            iv_d = iv_q;
        end

        if (dec_tvalid) begin
            pt_tdata_d  = dec_tdata ^ chain_mask(state_q, iv_q, prev_ct_q);
            pt_tvalid_d = 1'b1;
            pt_tlast_d  = dec_tlast;
            prev_ct_d   = pop_entry.data;
            case (state_q)
                FIRST:   state_d = dec_tlast ? FIRST : CHAIN;
                CHAIN:   state_d = dec_tlast ? FIRST : CHAIN;
                default: state_d = FIRST;
            endcase
            if (!fifo_underflow && (pop_entry.last != dec_tlast)) begin
                err_sync_d = 1'b1;
            end else begin
                err_sync_d = err_sync_q;
            end
        end else begin
            state_d   = state_q;
            prev_ct_d = prev_ct_q;
        end

        if (fifo_overflow) begin
            err_overflow_d = 1'b1;
        end else begin
            err_overflow_d = err_overflow_q;
        end

        if (fifo_underflow) begin
            err_underflow_d = 1'b1;
        end else begin
            err_underflow_d = err_underflow_q;
        end
    end

    // Chaining state, IV, previous ciphertext, output and error registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= FIRST;
            iv_q            <= {AES_BLOCK_WIDTH{1'b0}};
            prev_ct_q       <= {AES_BLOCK_WIDTH{1'b0}};
            pt_tdata_q      <= {AES_BLOCK_WIDTH{1'b0}};
            pt_tvalid_q     <= 1'b0;
            pt_tlast_q      <= 1'b0;
            err_overflow_q  <= 1'b0;
            err_underflow_q <= 1'b0;
            err_sync_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            iv_q            <= iv_d;
            prev_ct_q       <= prev_ct_d;
            pt_tdata_q      <= pt_tdata_d;
            pt_tvalid_q     <= pt_tvalid_d;
            pt_tlast_q      <= pt_tlast_d;
            err_overflow_q  <= err_overflow_d;
            err_underflow_q <= err_underflow_d;
            err_sync_q      <= err_sync_d;
        end
    end

    assign pt_tdata        = pt_tdata_q;
    assign pt_tvalid       = pt_tvalid_q;
    assign pt_tlast        = pt_tlast_q;
    assign err_overflow_o  = err_overflow_q;
    assign err_underflow_o = err_underflow_q;
    assign err_sync_o      = err_sync_q;

endmodule

// File: tb/tb_aes_cbc_dec_chain.sv
// Bench for aes_cbc_dec_chain: a queue-based 14-cycle pipeline stand-in feeds the
// dec port, and plaintext is predicted as D(C_i) ^ (packet start ? IV : C_{i-1}).
module tb_aes_cbc_dec_chain;
    import aes_cbc_dec_chain_pkg::*;

    localparam int LAT = 14;
    localparam logic [127:0] IV0    = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] FKEY   = 128'h3C4FCF098815F7ABA6D2AE2816157E2B;
    localparam logic [127:0] DEC_SA = 128'h6BC0BCE12A459991E134741A7F9E1925;

    typedef struct packed {
        int           due;
        logic [127:0] d;
        logic [127:0] prev;
        logic         first;
        logic         l;
    } pipe_t;

    logic         clk;
    logic         resetn;
    logic [127:0] iv_i;
    logic         iv_valid_i;
    logic [127:0] ct_tdata;
    logic         ct_tvalid;
    logic         ct_tlast;
    logic [127:0] dec_tdata;
    logic         dec_tvalid;
    logic         dec_tlast;
    logic [127:0] pt_tdata;
    logic         pt_tvalid;
    logic         pt_tlast;
    logic         err_overflow_o;
    logic         err_underflow_o;
    logic         err_sync_o;

    int           n_checks;
    int           n_pass;
    int           cyc;
    pipe_t        pipe [$];
    logic [127:0] m_iv;
    logic [127:0] m_prev_c;
    logic         m_next_first;
    logic [127:0] last_pt;
    logic [127:0] exp_d;
    logic         exp_l;
    logic         fired;
    logic [127:0] c_tab [4];
    logic [127:0] p_tab [4];

    aes_cbc_dec_chain #(.DEPTH(16)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .iv_i            (iv_i),
        .iv_valid_i      (iv_valid_i),
        .ct_tdata        (ct_tdata),
        .ct_tvalid       (ct_tvalid),
        .ct_tlast        (ct_tlast),
        .dec_tdata       (dec_tdata),
        .dec_tvalid      (dec_tvalid),
        .dec_tlast       (dec_tlast),
        .pt_tdata        (pt_tdata),
        .pt_tvalid       (pt_tvalid),
        .pt_tlast        (pt_tlast),
        .err_overflow_o  (err_overflow_o),
        .err_underflow_o (err_underflow_o),
        .err_sync_o      (err_sync_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick_raw(input logic cv, input logic [127:0] cd, input logic cl,
                            input logic ivv, input logic [127:0] ivd,
                            input logic dv, input logic [127:0] dd, input logic dl);
        ct_tvalid  = cv;
        ct_tdata   = cd;
        ct_tlast   = cl;
        iv_valid_i = ivv;
        iv_i       = ivd;
        dec_tvalid = dv;
        dec_tdata  = dd;
        dec_tlast  = dl;
        @(posedge clk);
        #1;
    endtask

    // One cycle through the pipeline stand-in; dval is the raw decryption of cd.
    task automatic tick(input logic cv, input logic [127:0] cd, input logic [127:0] dval,
                        input logic cl, input logic ivv, input logic [127:0] ivd);
        pipe_t        e;
        logic         dv;
        logic [127:0] dd;
        logic         dl;
        if (cv) begin
            e.due   = cyc + LAT;
            e.d     = dval;
            e.l     = cl;
            e.first = m_next_first;
            e.prev  = m_prev_c;
            pipe.push_back(e);
            m_prev_c     = cd;
            m_next_first = cl;
        end
        fired = 1'b0;
        dv    = 1'b0;
        dd    = '0;
        dl    = 1'b0;
        if (pipe.size() > 0 && pipe[0].due == cyc) begin
            e     = pipe.pop_front();
            fired = 1'b1;
            dv    = 1'b1;
            dd    = e.d;
            dl    = e.l;
            exp_d = e.d ^ (e.first ? m_iv : e.prev);
            exp_l = e.l;
        end
        tick_raw(cv, cd, cl, ivv, ivd, dv, dd, dl);
        cyc++;
        if (ivv) m_iv = ivd;
        if (fired) last_pt = exp_d;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick_raw(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        tick_raw(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        resetn       = 1'b1;
        m_iv         = '0;
        m_prev_c     = '0;
        m_next_first = 1'b1;
        last_pt      = '0;
        cyc          = 0;
        pipe.delete();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick_raw(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        n_checks++;
        if ({pt_tvalid, pt_tlast, pt_tdata, err_overflow_o, err_underflow_o, err_sync_o} !== 134'd0)
            $display("FAIL reset_outputs: got v=%b l=%b d=%h err=%b%b%b want all 0",
                     pt_tvalid, pt_tlast, pt_tdata, err_overflow_o, err_underflow_o, err_sync_o);
        else n_pass++;
        n_checks++;
        if (dut.state_q !== FIRST || dut.u_ct_fifo.count_o !== 5'd0)
            $display("FAIL reset_state: got state=%0d count=%0d want 0/0", dut.state_q, dut.u_ct_fifo.count_o);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_standalone();
        int seen;
        seen = 0;
        tick(1'b0, '0, '0, 1'b0, 1'b1, IV0);
        for (int t = 0; t < LAT + 3; t++) begin
            tick(t == 0, c_tab[0], DEC_SA, 1'b1, 1'b0, '0);
            if (fired) begin
                seen++;
                n_checks++;
                if ({pt_tvalid, pt_tlast, pt_tdata} !== {1'b1, 1'b1, p_tab[0]})
                    $display("FAIL standalone_pt: got v=%b l=%b %h want v=1 l=1 %h", pt_tvalid, pt_tlast, pt_tdata, p_tab[0]);
                else n_pass++;
                n_checks++;
                if (dut.state_q !== FIRST)
                    $display("FAIL standalone_state: got %0d want FIRST", dut.state_q);
                else n_pass++;
            end
        end
        n_checks++;
        if (seen != 1) $display("FAIL standalone_beats: got %0d want 1", seen);
        else n_pass++;
    endtask

    task automatic test_end_to_end();
        int           k;
        logic         cv;
        logic [127:0] cd;
        logic [127:0] dv;
        k = 0;
        for (int t = 0; t < LAT + 8; t++) begin
            cv = (t < 4);
            cd = '0;
            dv = '0;
            if (t < 4) begin
                cd = c_tab[t];
                dv = p_tab[t] ^ ((t == 0) ? IV0 : c_tab[(t + 3) % 4]);
            end
            tick(cv, cd, dv, t == 3, 1'b0, '0);
            if (fired && k < 4) begin
                n_checks++;
                if ({pt_tvalid, pt_tlast, pt_tdata} !== {1'b1, (k == 3), p_tab[k]})
                    $display("FAIL e2e_block%0d: got v=%b l=%b %h want v=1 l=%b %h", k, pt_tvalid, pt_tlast, pt_tdata, (k == 3), p_tab[k]);
                else n_pass++;
                k++;
            end else if (!fired) begin
                n_checks++;
                if ({pt_tvalid, pt_tdata} !== {1'b0, last_pt})
                    $display("FAIL e2e_idle: got v=%b %h want v=0 %h", pt_tvalid, pt_tdata, last_pt);
                else n_pass++;
            end
        end
        n_checks++;
        if (k != 4 || {err_overflow_o, err_underflow_o, err_sync_o} !== 3'b000)
            $display("FAIL e2e_end: got beats=%0d err=%b%b%b want 4 beats, 000", k, err_overflow_o, err_underflow_o, err_sync_o);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [127:0] c [8];
        logic [127:0] iv1;
        logic [127:0] iv2;
        iv1 = rnd128();
        iv2 = rnd128();
        for (int i = 0; i < 8; i++) c[i] = rnd128();
        tick(1'b0, '0, '0, 1'b0, 1'b1, iv1);
        for (int t = 0; t < LAT + 10; t++) begin
            if (t < 8) tick(1'b1, c[t], c[t] ^ FKEY, (t == 3) || (t == 7), 1'b0, '0);
            else       tick(1'b0, '0, '0, 1'b0, (t == LAT + 1), iv2);
            if (fired) begin
                n_checks++;
                if ({pt_tvalid, pt_tlast, pt_tdata} !== {1'b1, exp_l, exp_d})
                    $display("FAIL b2b_beat: got v=%b l=%b %h want v=1 l=%b %h", pt_tvalid, pt_tlast, pt_tdata, exp_l, exp_d);
                else n_pass++;
            end
            if (t == LAT + 4) begin
                n_checks++;
                if (pt_tdata !== (c[4] ^ FKEY ^ iv2))
                    $display("FAIL b2b_new_iv: got %h want %h", pt_tdata, c[4] ^ FKEY ^ iv2);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random_stream();
        int           pk;
        int           rem;
        int           t;
        logic         cv;
        logic         cl;
        logic [127:0] cd;
        pk  = 0;
        rem = $urandom_range(1, 5);
        t   = 0;
        while (t < 400 && (pk < 6 || pipe.size() > 0)) begin
            cv = 1'b0;
            cl = 1'b0;
            cd = '0;
            if (pk < 6 && $urandom_range(0, 3) != 0) begin
                cv = 1'b1;
                cd = rnd128();
                rem--;
                cl = (rem == 0);
                if (cl) begin
                    pk++;
                    rem = $urandom_range(1, 5);
                end
            end
            tick(cv, cd, cd ^ FKEY, cl, $urandom_range(0, 5) == 0, rnd128());
            n_checks++;
            if (fired) begin
                if ({pt_tvalid, pt_tlast, pt_tdata} !== {1'b1, exp_l, exp_d})
                    $display("FAIL rand_beat: got v=%b l=%b %h want v=1 l=%b %h", pt_tvalid, pt_tlast, pt_tdata, exp_l, exp_d);
                else n_pass++;
            end else begin
                if ({pt_tvalid, pt_tdata} !== {1'b0, last_pt})
                    $display("FAIL rand_idle: got v=%b %h want v=0 %h", pt_tvalid, pt_tdata, last_pt);
                else n_pass++;
            end
            t++;
        end
        n_checks++;
        if (pipe.size() != 0 || {err_overflow_o, err_underflow_o, err_sync_o} !== 3'b000)
            $display("FAIL rand_end: got pending=%0d err=%b%b%b want 0, 000", pipe.size(), err_overflow_o, err_underflow_o, err_sync_o);
        else n_pass++;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            tick_raw(1'b1, rnd128(), 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
            if (i == 16) begin
                n_checks++;
                if (err_overflow_o !== 1'b0 || dut.u_ct_fifo.count_o !== 5'd16)
                    $display("FAIL ovf_at16: got err=%b count=%0d want 0/16", err_overflow_o, dut.u_ct_fifo.count_o);
                else n_pass++;
            end
            if (i == 17) begin
                n_checks++;
                if ({err_overflow_o, err_underflow_o, err_sync_o} !== 3'b100 || dut.u_ct_fifo.count_o !== 5'd16)
                    $display("FAIL ovf_at17: got err=%b%b%b count=%0d want 100/16",
                             err_overflow_o, err_underflow_o, err_sync_o, dut.u_ct_fifo.count_o);
                else n_pass++;
            end
        end
    endtask

    task automatic test_underflow_sync();
        logic [127:0] iv;
        logic [127:0] a;
        logic [127:0] b;
        do_reset();
        iv = rnd128();
        a  = rnd128();
        b  = rnd128();
        tick_raw(1'b0, '0, 1'b0, 1'b1, iv, 1'b0, '0, 1'b0);
        tick_raw(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, a, 1'b1);
        n_checks++;
        if ({pt_tvalid, pt_tdata, err_underflow_o, err_sync_o} !== {1'b1, a ^ iv, 1'b1, 1'b0} || dut.u_ct_fifo.count_o !== 5'd0)
            $display("FAIL underflow: got v=%b %h uf=%b sy=%b count=%0d want v=1 %h uf=1 sy=0 count=0",
                     pt_tvalid, pt_tdata, err_underflow_o, err_sync_o, dut.u_ct_fifo.count_o, a ^ iv);
        else n_pass++;
        tick_raw(1'b1, rnd128(), 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        tick_raw(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, b, 1'b0);
        n_checks++;
        if ({pt_tvalid, pt_tlast, pt_tdata, err_sync_o, err_overflow_o} !== {1'b1, 1'b0, b ^ iv, 1'b1, 1'b0})
            $display("FAIL sync: got v=%b l=%b %h sy=%b of=%b want v=1 l=0 %h sy=1 of=0",
                     pt_tvalid, pt_tlast, pt_tdata, err_sync_o, err_overflow_o, b ^ iv);
        else n_pass++;
    endtask

    task automatic test_reset_midpacket();
        int k;
        do_reset();
        tick(1'b0, '0, '0, 1'b0, 1'b1, IV0);
        k = 0;
        for (int t = 0; t < LAT + 2; t++) begin
            if (t < 4) tick(1'b1, c_tab[t], p_tab[t] ^ ((t == 0) ? IV0 : c_tab[(t + 3) % 4]), t == 3, 1'b0, '0);
            else       tick(1'b0, '0, '0, 1'b0, 1'b0, '0);
            if (fired) k++;
        end
        #2;
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({pt_tvalid, pt_tlast, pt_tdata, err_overflow_o, err_underflow_o, err_sync_o} !== 134'd0 ||
            dut.state_q !== FIRST || dut.u_ct_fifo.count_o !== 5'd0 || k != 2)
            $display("FAIL midreset: got v=%b l=%b %h err=%b%b%b count=%0d beats=%0d want all 0, beats 2",
                     pt_tvalid, pt_tlast, pt_tdata, err_overflow_o, err_underflow_o, err_sync_o, dut.u_ct_fifo.count_o, k);
        else n_pass++;
        do_reset();
        tick(1'b0, '0, '0, 1'b0, 1'b1, IV0);
        k = 0;
        for (int t = 0; t < LAT + 6; t++) begin
            if (t < 4) tick(1'b1, c_tab[t], p_tab[t] ^ ((t == 0) ? IV0 : c_tab[(t + 3) % 4]), t == 3, 1'b0, '0);
            else       tick(1'b0, '0, '0, 1'b0, 1'b0, '0);
            if (fired && k < 4) begin
                n_checks++;
                if ({pt_tvalid, pt_tlast, pt_tdata} !== {1'b1, (k == 3), p_tab[k]})
                    $display("FAIL replay_block%0d: got v=%b l=%b %h want v=1 l=%b %h", k, pt_tvalid, pt_tlast, pt_tdata, (k == 3), p_tab[k]);
                else n_pass++;
                k++;
            end
        end
        n_checks++;
        if (k != 4) $display("FAIL replay_beats: got %0d want 4", k);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        resetn   = 1'b0;
        tick_raw_init();
        c_tab[0] = 128'hF58C4C04D6E5F1BA779EABFB5F7BFBD6;
        c_tab[1] = 128'h9CFC4E967EDB808D679F777BC6702C7D;
        c_tab[2] = 128'h39F23369A9D9BACFA530E26304231461;
        c_tab[3] = 128'hB2EB05E2C39BE9FCDA6C19078C6A9D1B;
        p_tab[0] = 128'h6BC1BEE22E409F96E93D7E117393172A;
        p_tab[1] = 128'hAE2D8A571E03AC9C9EB76FAC45AF8E51;
        p_tab[2] = 128'h30C81C46A35CE411E5FBC1191A0A52EF;
        p_tab[3] = 128'hF69F2445DF4F9B17AD2B417BE66C3710;
        test_reset();
        test_standalone();
        test_end_to_end();
        test_back_to_back();
        test_random_stream();
        test_overflow();
        test_underflow_sync();
        test_reset_midpacket();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    task automatic tick_raw_init();
        ct_tvalid  = 1'b0;
        ct_tdata   = '0;
        ct_tlast   = 1'b0;
        iv_valid_i = 1'b0;
        iv_i       = '0;
        dec_tvalid = 1'b0;
        dec_tdata  = '0;
        dec_tlast  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
